uart_rx_cmd_parser: RTL and testbench
=====================================

Name: uart_rx_cmd_parser

Overview:
Frame controller sitting directly behind the UART receiver. It consumes the one-cycle RxD_data_ready/RxD_data byte strobe, sequences bytes through a framing state machine (sync, command, length, payload, checksum), buffers the payload and presents a validated command to downstream logic with a valid/ack handshake. Malformed, stalled or overrun traffic is discarded and flagged with one-cycle error pulses.

Parameters:
MAX_LEN, 16, maximum payload bytes accepted per frame (1..2^ADDR_W)
ADDR_W, 4, payload buffer address width
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_TICKS, 256, OversamplingTick count allowed between bytes inside a frame (only with PARSER_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
OversamplingTick  in  1  baud oversampling tick, same tick that drives the receiver
RxD_data_ready  in  1  one-cycle byte strobe from receiver
RxD_data  in  8  received byte, valid with RxD_data_ready
cmd_valid  out  1  validated command pending
cmd_ack  in  1  consumer accepts command; honoured only while cmd_valid=1
cmd_code  out  8  command byte of pending frame
cmd_len  out  8  payload length of pending frame
rd_addr  in  ADDR_W  payload buffer read address
rd_data  out  8  payload byte at rd_addr, registered (1-cycle read latency)
err_chk  out  1  one-cycle pulse: checksum mismatch
err_len  out  1  one-cycle pulse: LEN > MAX_LEN
err_timeout  out  1  one-cycle pulse: inter-byte timeout
err_overrun  out  1  one-cycle pulse: byte arrived while command pending

Behaviour:
- One clock, synchronous active-high reset. Reset values: state=IDLE, cmd_valid=0, cmd_code=0, cmd_len=0, rd_data=0, all err_* =0, checksum=0, byte counter=0. Reset mid-frame discards the frame; buffer contents undefined, not cleared.
- "Byte event" = RxD_data_ready=1 in a cycle. All state moves occur only on byte events except HOLD exit and timeout.
- States:
  - IDLE: byte==SYNC_BYTE -> GET_CMD; other bytes ignored silently.
  - GET_CMD: latch cmd_code, chk<=byte -> GET_LEN.
  - GET_LEN: LEN>MAX_LEN -> err_len pulse, IDLE. LEN==0 -> GET_CHK. else -> GET_PAY; cnt<=0. chk<=chk^byte; latch cmd_len.
  - GET_PAY: write byte to buffer[cnt], chk^=byte, cnt+=1; when cnt==cmd_len-1 on this byte -> GET_CHK.
  - GET_CHK: byte==chk -> HOLD; else err_chk pulse, IDLE.
  - HOLD: cmd_valid=1; cmd_code/cmd_len stable. cmd_ack=1 -> IDLE, cmd_valid=0 next cycle.
- Latency: cmd_valid rises the cycle after the checksum byte event.
- A SYNC_BYTE value received mid-frame is treated as data, no resync.
- Byte event in HOLD (including the ack cycle): byte dropped, err_overrun pulse, pending command unaffected.
- Buffer writes occur only in GET_PAY; rd_data reads continuously, valid 1 cycle after rd_addr; buffer stable while cmd_valid=1.
- Error pulses are mutually exclusive per cycle, registered, exactly one cycle wide.
- cnt width ADDR_W+1; no wrap possible since LEN<=MAX_LEN is enforced.

Optional Feature:
PARSER_TIMEOUT_EN
- Defined: counter increments on OversamplingTick in GET_CMD/GET_LEN/GET_PAY/GET_CHK, clears on every byte event and on entering IDLE. Reaching TIMEOUT_TICKS -> err_timeout pulse, IDLE. Byte event in same cycle as expiry wins: byte processed, counter cleared, no error. Counter inactive in IDLE and HOLD.
- Undefined: no counter; a stalled frame waits indefinitely; err_timeout tied 0.

Test Plan:
- Bytes A5 01 02 11 22 30 -> cmd_valid=1 one cycle after 0x30, cmd_code=01, cmd_len=02, rd_addr 0/1 -> 11/22; cmd_ack -> cmd_valid=0 next cycle.
- Bytes A5 07 00 07 -> cmd_valid=1, cmd_len=0; no buffer writes.
- Bytes A5 01 02 11 22 31 -> err_chk single pulse, cmd_valid stays 0; following good frame accepted normally.
- Bytes 00 FF A5 01 20 -> leading bytes ignored, err_len pulse on 0x20, back to IDLE.
- With PARSER_TIMEOUT_EN: A5 01 then 256 ticks idle -> err_timeout pulse; then A5 02 00 02 -> cmd_valid=1, cmd_code=02.
- Pending command held, send 0x55 and also 0x66 in ack cycle -> two err_overrun pulses, cmd_code/cmd_len unchanged; reset asserted mid-payload -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/uart_rx_cmd_parser_if.sv
// Bus between the UART frame parser and its neighbours: receiver byte strobe, oversampling
// tick, command handshake, payload read port and error pulses.
interface uart_rx_cmd_parser_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              OversamplingTick;
  logic              RxD_data_ready;
  logic [7:0]        RxD_data;
  logic              cmd_valid;
  logic              cmd_ack;
  logic [7:0]        cmd_code;
  logic [7:0]        cmd_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              err_chk;
  logic              err_len;
  logic              err_timeout;
  logic              err_overrun;

  // Parser side.
  modport master (
    input  OversamplingTick, RxD_data_ready, RxD_data, cmd_ack, rd_addr,
    output cmd_valid, cmd_code, cmd_len, rd_data,
    output err_chk, err_len, err_timeout, err_overrun
  );

  // Receiver / command consumer side.
  modport slave (
    output OversamplingTick, RxD_data_ready, RxD_data, cmd_ack, rd_addr,
    input  cmd_valid, cmd_code, cmd_len, rd_data,
    input  err_chk, err_len, err_timeout, err_overrun
  );
endinterface

// File: rtl/uart_rx_cmd_parser.sv
// Frames received UART bytes (sync, cmd, len, payload, xor checksum) into validated commands.
// Define PARSER_TIMEOUT_EN to abort frames that stall for TIMEOUT_TICKS oversampling ticks.
module uart_rx_cmd_parser #(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned ADDR_W        = 4,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_TICKS = 256
) (
  input logic                  clk,
  input logic                  reset,
  uart_rx_cmd_parser_if.master bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StGetCmd,
    StGetLen,
    StGetPay,
    StGetChk,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        cmd_code_q, cmd_code_d;
  logic [7:0]        cmd_len_q, cmd_len_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_chk_q, err_chk_d;
  logic              err_len_q, err_len_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_overrun_q, err_overrun_d;
  logic [7:0]        rd_data_q;

  logic [7:0]        buf_q [Depth];
  logic              buf_we;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_wdata;

  logic              byte_ev;
  logic              tmo_expired;

  assign byte_ev = bus.RxD_data_ready;

`ifdef PARSER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_TICKS + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            in_frame;

  assign in_frame = (state_q == StGetCmd) || (state_q == StGetLen) ||
                    (state_q == StGetPay) || (state_q == StGetChk);

  // A byte arriving on the expiry cycle wins: the counter simply clears.
  always_comb begin
    tmo_d       = tmo_q;
    tmo_expired = 1'b0;
    if (!in_frame || byte_ev) begin
      tmo_d = '0;
    end else if (bus.OversamplingTick) begin
      if (32'(tmo_q) + 32'd1 >= TIMEOUT_TICKS) begin
        tmo_expired = 1'b1;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo;

  assign tmo_expired = 1'b0;
  assign unused_tmo  = bus.OversamplingTick ^ (TIMEOUT_TICKS != 0);
`endif

  always_comb begin
    state_d       = state_q;
    cmd_code_d    = cmd_code_q;
    cmd_len_d     = cmd_len_q;
    chk_d         = chk_q;
    cnt_d         = cnt_q;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    buf_we        = 1'b0;
    buf_waddr     = cnt_q[ADDR_W-1:0];
    buf_wdata     = bus.RxD_data;

    unique case (state_q)
      StIdle: begin
        if (byte_ev && bus.RxD_data == SYNC_BYTE) begin
          state_d = StGetCmd;
        end
      end
      StGetCmd: begin
        if (byte_ev) begin
          cmd_code_d = bus.RxD_data;
          chk_d      = bus.RxD_data;
          state_d    = StGetLen;
        end
      end
      StGetLen: begin
        if (byte_ev) begin
          chk_d     = chk_q ^ bus.RxD_data;
          cmd_len_d = bus.RxD_data;
          cnt_d     = '0;
          if (32'(bus.RxD_data) > MAX_LEN) begin
            err_len_d = 1'b1;
            state_d   = StIdle;
          end else if (bus.RxD_data == 8'd0) begin
            state_d = StGetChk;
          end else begin
            state_d = StGetPay;
          end
        end
      end
      StGetPay: begin
        if (byte_ev) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ bus.RxD_data;
          cnt_d  = cnt_q + (ADDR_W + 1)'(1);
          if (32'(cnt_q) + 32'd1 == 32'(cmd_len_q)) begin
            state_d = StGetChk;
          end
        end
      end
      StGetChk: begin
        if (byte_ev) begin
          if (bus.RxD_data == chk_q) begin
            state_d = StHold;
          end else begin
            err_chk_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StHold: begin
        // Bytes are dropped while a command is pending, even on the ack cycle.
        if (byte_ev) begin
          err_overrun_d = 1'b1;
        end
        if (bus.cmd_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (tmo_expired) begin
      err_timeout_d = 1'b1;
      state_d       = StIdle;
    end

    cmd_valid_d = (state_d == StHold);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= 8'd0;
      cmd_len_q     <= 8'd0;
      chk_q         <= 8'd0;
      cnt_q         <= '0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      rd_data_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      cmd_len_q     <= cmd_len_d;
      chk_q         <= chk_d;
      cnt_q         <= cnt_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
      rd_data_q     <= buf_q[bus.rd_addr];
    end
  end

  // Payload storage has no reset; contents are only meaningful for the pending command.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[buf_waddr] <= buf_wdata;
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_code    = cmd_code_q;
  assign bus.cmd_len     = cmd_len_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Scoreboard bench for uart_rx_cmd_parser: a frame-level model predicts commands and error
// pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_uart_rx_cmd_parser;

  localparam int unsigned MaxLen = 16;
  localparam int unsigned AddrW  = 4;
  localparam logic [7:0]  Sync   = 8'hA5;

  localparam int EvCmd = 0;
  localparam int EvChk = 1;
  localparam int EvLen = 2;
  localparam int EvTmo = 3;
  localparam int EvOvr = 4;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic [7:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_rx_cmd_parser_if #(.ADDR_W(AddrW)) bus ();

  uart_rx_cmd_parser #(
    .MAX_LEN      (MaxLen),
    .ADDR_W       (AddrW),
    .SYNC_BYTE    (Sync),
    .TIMEOUT_TICKS(256)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       sb_q[$];
  logic [7:0] frame[$];
  logic [7:0] m_pay[$];
  logic [7:0] seq[$];
  logic [7:0] m_code;
  logic [7:0] m_len;
  bit         m_hold = 1'b0;
  bit         mon_cv_prev;
  logic [3:0] mon_errs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int kind, input logic [7:0] code, input logic [7:0] len);
    exp_t e;
    e.kind = kind;
    e.code = code;
    e.len  = len;
    sb_q.push_back(e);
  endfunction

  // Frame-level reference: collect bytes from a sync until the frame is complete, then judge it.
  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] x;
    if (m_hold) begin
      push_exp(EvOvr, 8'd0, 8'd0);
      return;
    end
    if (frame.size() == 0) begin
      if (b == Sync) frame.push_back(b);
      return;
    end
    frame.push_back(b);
    if (frame.size() == 3 && int'(b) > int'(MaxLen)) begin
      push_exp(EvLen, 8'd0, 8'd0);
      frame.delete();
    end else if (frame.size() >= 4 && frame.size() == 4 + int'(frame[2])) begin
      x = 8'd0;
      for (int i = 1; i < frame.size() - 1; i++) x ^= frame[i];
      if (x == b) begin
        m_code = frame[1];
        m_len  = frame[2];
        m_pay.delete();
        for (int i = 3; i < frame.size() - 1; i++) m_pay.push_back(frame[i]);
        m_hold = 1'b1;
        push_exp(EvCmd, m_code, m_len);
      end else begin
        push_exp(EvChk, 8'd0, 8'd0);
      end
      frame.delete();
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit with_ack);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk);
    #1;
    bus.RxD_data_ready = 1'b1;
    bus.RxD_data       = b;
    bus.cmd_ack        = with_ack;
    model_byte(b);
    if (with_ack) m_hold = 1'b0;
    @(posedge clk);
    #1;
    bus.RxD_data_ready = 1'b0;
    bus.cmd_ack        = 1'b0;
  endtask

  task automatic send_seq();
    for (int i = 0; i < seq.size(); i++) send_byte(seq[i], 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] code, input int len, input bit bad_chk);
    logic [7:0] x;
    logic [7:0] d;
    send_byte(Sync, 1'b0);
    send_byte(code, 1'b0);
    send_byte(8'(len), 1'b0);
    x = code ^ 8'(len);
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom);
      send_byte(d, 1'b0);
      x ^= d;
    end
    if (bad_chk) x ^= 8'($urandom_range(1, 255));
    send_byte(x, 1'b0);
  endtask

  // Called straight after the checksum byte; reads the payload back and acknowledges.
  task automatic consume(input int n_ovr, input bit ack_byte);
    int waited = 0;
    while (!bus.cmd_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_valid_latency", 32'(waited), 32'd0);
    if (!bus.cmd_valid) begin
      m_hold = 1'b0;
      return;
    end
    for (int i = 0; i < int'(m_len); i++) begin
      bus.rd_addr = AddrW'(i);
      @(posedge clk);
      #1;
      check("rd_data", {24'd0, bus.rd_data}, {24'd0, m_pay[i]});
    end
    for (int k = 0; k < n_ovr; k++) send_byte(8'h55 + 8'(k), 1'b0);
    check("hold_cmd_code", {24'd0, bus.cmd_code}, {24'd0, m_code});
    check("hold_cmd_len", {24'd0, bus.cmd_len}, {24'd0, m_len});
    if (ack_byte) begin
      send_byte(8'h66, 1'b1);
    end else begin
      @(posedge clk);
      #1;
      bus.cmd_ack = 1'b1;
      m_hold      = 1'b0;
      @(posedge clk);
      #1;
      bus.cmd_ack = 1'b0;
    end
    check("cmd_valid_after_ack", {31'd0, bus.cmd_valid}, 32'd0);
  endtask

  task automatic expect_ev(input int kind);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
      return;
    end
    e = sb_q.pop_front();
    check("event_kind", 32'(kind), 32'(e.kind));
    if (kind == EvCmd && e.kind == EvCmd) begin
      check("cmd_code", {24'd0, bus.cmd_code}, {24'd0, e.code});
      check("cmd_len", {24'd0, bus.cmd_len}, {24'd0, e.len});
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
    check("rst_cmd_code", {24'd0, bus.cmd_code}, 32'd0);
    check("rst_cmd_len", {24'd0, bus.cmd_len}, 32'd0);
    check("rst_rd_data", {24'd0, bus.rd_data}, 32'd0);
    check("rst_errs", {28'd0, bus.err_chk, bus.err_len, bus.err_timeout, bus.err_overrun}, 32'd0);
  endtask

  // Monitor.
  initial begin
    mon_cv_prev = 1'b0;
    forever begin
      @(negedge clk);
      mon_errs = {bus.err_chk, bus.err_len, bus.err_timeout, bus.err_overrun};
      if (!reset) begin
        if (mon_errs != 4'd0) check("err_onehot", 32'($countones(mon_errs)), 32'd1);
        if (bus.cmd_valid && !mon_cv_prev) expect_ev(EvCmd);
        if (bus.err_chk) expect_ev(EvChk);
        if (bus.err_len) expect_ev(EvLen);
        if (bus.err_timeout) expect_ev(EvTmo);
        if (bus.err_overrun) expect_ev(EvOvr);
      end
      mon_cv_prev = bus.cmd_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind;
    bus.OversamplingTick = 1'b0;
    bus.RxD_data_ready   = 1'b0;
    bus.RxD_data         = 8'd0;
    bus.cmd_ack          = 1'b0;
    bus.rd_addr          = '0;
    reset                = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;

    // Basic two-byte payload, with overruns during hold and on the ack cycle.
    seq = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
    send_seq();
    consume(1, 1'b1);

    // Zero-length payload.
    seq = '{8'hA5, 8'h07, 8'h00, 8'h07};
    send_seq();
    consume(0, 1'b0);

    // Bad checksum then a good frame.
    seq = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h31};
    send_seq();
    seq = '{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30};
    send_seq();
    consume(0, 1'b0);

    // Leading junk, then an over-long length.
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h20};
    send_seq();

    // Reset mid-payload.
    seq = '{8'hA5, 8'h03, 8'h04, 8'h11, 8'h22};
    send_seq();
    @(posedge clk);
    #1;
    reset = 1'b1;
    frame.delete();
    @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    send_frame(8'h3C, 3, 1'b0);
    consume(0, 1'b0);

`ifdef PARSER_TIMEOUT_EN
    seq = '{8'hA5, 8'h01};
    send_seq();
    push_exp(EvTmo, 8'd0, 8'd0);
    frame.delete();
    bus.OversamplingTick = 1'b1;
    repeat (256) @(posedge clk);
    #1;
    bus.OversamplingTick = 1'b0;
    repeat (3) @(posedge clk);
    seq = '{8'hA5, 8'h02, 8'h00, 8'h02};
    send_seq();
    consume(0, 1'b0);
`endif

    // Randomised traffic.
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 8'hA4)), 1'b0);
      kind = int'($urandom_range(0, 4));
      case (kind)
        0, 1: begin
          send_frame(8'($urandom), int'($urandom_range(0, MaxLen)), 1'b0);
          consume(0, 1'b0);
        end
        2: send_frame(8'($urandom), int'($urandom_range(0, MaxLen)), 1'b1);
        3: begin
          send_byte(Sync, 1'b0);
          send_byte(8'($urandom), 1'b0);
          send_byte(8'($urandom_range(MaxLen + 1, 255)), 1'b0);
        end
        default: begin
          send_frame(8'($urandom), int'($urandom_range(1, MaxLen)), 1'b0);
          consume(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end
      endcase
    end

    repeat (10) @(posedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
